// File: rtl/udp_tx_buffer.sv
// Packet buffer behind the UDP encoder: stores header+payload words, patches the
// checksum into header word 1 on fin, then drains the packet on a valid/ready stream.
module udp_tx_buffer #(
  parameter int unsigned ADDR_W        = 9,
  parameter bit          INVERT_CHKSUM = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pkg_data,
  input  logic        wr_en,
  input  logic        fin,
  input  logic [15:0] checksum_in,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic [1:0]  err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LEN_IDX = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PATCH, S_DRAIN} state_e;

  logic [31:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              fin_q;
  logic [15:0]       chk_q, chk_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic [1:0]        err_q, err_d;

  logic              fin_edge_c;
  logic              full_c;
  logic [15:0]       chk_c;
  logic [ADDR_W-1:0] rd_idx_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [31:0]       mem_wdata_c;

  assign fin_edge_c = fin && !fin_q;
  assign full_c     = (cnt_q == CNT_W'(DEPTH));
  assign rd_idx_c   = rd_ptr_q[ADDR_W-1:0];

  // Zero stays zero (checksum disabled); an inverted result of zero is sent as all-ones.
  always_comb begin
    chk_c = checksum_in;
    if (INVERT_CHKSUM) begin
      if (checksum_in == 16'h0000)      chk_c = 16'h0000;
      else if (checksum_in == 16'hFFFF) chk_c = 16'hFFFF;
      else                              chk_c = ~checksum_in;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_ptr_d    = rd_ptr_q;
    chk_d       = chk_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    mem_we_c    = 1'b0;
    mem_addr_c  = cnt_q[ADDR_W-1:0];
    mem_wdata_c = pkg_data;

    case (state_q)
      S_IDLE, S_FILL: begin
        if (wr_en) begin
          if (full_c) begin
            err_d[0] = 1'b1;
          end else begin
            mem_we_c = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
            state_d  = S_FILL;
          end
        end
        // Same-cycle word is already counted in cnt_d.
        if (fin_edge_c) begin
          if (cnt_d < CNT_W'(2)) begin
            err_d[1] = 1'b1;
            cnt_d    = '0;
            state_d  = S_IDLE;
          end else begin
            chk_d   = chk_c;
            state_d = S_PATCH;
          end
        end
      end
      S_PATCH: begin
        if (wr_en) err_d[0] = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = LEN_IDX;
        mem_wdata_c = {mem[LEN_IDX][31:16], chk_q};
        rd_ptr_d    = '0;
        state_d     = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_en) err_d[0] = 1'b1;
        if (!out_valid_q || out_ready) begin
          if (out_valid_q && out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end else begin
            out_data_d  = mem[rd_idx_c];
            out_valid_d = 1'b1;
            out_last_d  = (rd_ptr_q == cnt_q - CNT_W'(1));
            rd_ptr_d    = rd_ptr_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      fin_q       <= 1'b0;
      chk_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      fin_q       <= fin;
      chk_q       <= chk_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  // Word RAM: single write port shared by fill and checksum patch.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_addr_c] <= mem_wdata_c;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_udp_tx_buffer.sv
// Bench for udp_tx_buffer: three instances (default, non-inverting, 4-word buffer)
// share one stimulus and are checked every cycle against a packet-level model.
module tb_udp_tx_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pkg_data;
  logic        wr_en;
  logic        fin;
  logic [15:0] checksum_in;
  logic        out_ready;

  logic [31:0] od [3];
  logic [2:0]  ov, ol, bz;
  logic [1:0]  er [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  udp_tx_buffer #(.ADDR_W(9), .INVERT_CHKSUM(1'b1)) dut_a (
    .clk(clk), .reset(reset), .pkg_data(pkg_data), .wr_en(wr_en), .fin(fin),
    .checksum_in(checksum_in), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_last(ol[0]), .busy(bz[0]), .err(er[0]));

  udp_tx_buffer #(.ADDR_W(9), .INVERT_CHKSUM(1'b0)) dut_b (
    .clk(clk), .reset(reset), .pkg_data(pkg_data), .wr_en(wr_en), .fin(fin),
    .checksum_in(checksum_in), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_last(ol[1]), .busy(bz[1]), .err(er[1]));

  udp_tx_buffer #(.ADDR_W(2), .INVERT_CHKSUM(1'b1)) dut_c (
    .clk(clk), .reset(reset), .pkg_data(pkg_data), .wr_en(wr_en), .fin(fin),
    .checksum_in(checksum_in), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .out_last(ol[2]), .busy(bz[2]), .err(er[2]));

  // ---------------- packet-level model ----------------
  localparam int MDEPTH [3] = '{512, 512, 4};
  localparam bit MINV   [3] = '{1'b1, 1'b0, 1'b1};

  logic [31:0] mpkt [3][0:511];
  int          msize [3];
  int          mphase [3];   // 0 collect, 1 checksum pending, 2 sending
  int          midx [3];
  bit          mvld [3];
  logic [15:0] mchk [3];
  logic [1:0]  merr [3];
  bit          mfin_prev;
  bit          mfe;

  function automatic logic [15:0] exp_chk(input logic [15:0] c, input bit inv);
    if (!inv) return c;
    if (c == 16'h0000) return 16'h0000;
    if (c == 16'hFFFF) return 16'hFFFF;
    return ~c;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 3; m++) begin
        msize[m] = 0; mphase[m] = 0; midx[m] = 0; mvld[m] = 1'b0;
        mchk[m] = 16'h0; merr[m] = 2'b00;
      end
      mfin_prev = 1'b0;
    end else begin
      mfe = fin && !mfin_prev;
      for (int m = 0; m < 3; m++) begin
        case (mphase[m])
          0: begin
            if (wr_en) begin
              if (msize[m] < MDEPTH[m]) begin
                mpkt[m][msize[m]] = pkg_data;
                msize[m]++;
              end else merr[m][0] = 1'b1;
            end
            if (mfe) begin
              if (msize[m] < 2) begin
                merr[m][1] = 1'b1;
                msize[m] = 0;
              end else begin
                mchk[m] = exp_chk(checksum_in, MINV[m]);
                mphase[m] = 1;
              end
            end
          end
          1: begin
            if (wr_en) merr[m][0] = 1'b1;
            mpkt[m][1][15:0] = mchk[m];
            mphase[m] = 2;
          end
          default: begin
            if (wr_en) merr[m][0] = 1'b1;
            if (!mvld[m]) begin
              mvld[m] = 1'b1;
              midx[m] = 0;
            end else if (out_ready) begin
              if (midx[m] == msize[m] - 1) begin
                mvld[m] = 1'b0;
                msize[m] = 0;
                mphase[m] = 0;
              end else midx[m]++;
            end
          end
        endcase
      end
      mfin_prev = fin;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 3; m++) begin
      check($sformatf("valid%0d", m), 32'(ov[m]), 32'(mvld[m]));
      check($sformatf("busy%0d", m), 32'(bz[m]), 32'((mphase[m] != 0) || (msize[m] > 0)));
      check($sformatf("err%0d", m), 32'(er[m]), 32'(merr[m]));
      if (mvld[m]) begin
        check($sformatf("data%0d", m), od[m], mpkt[m][midx[m]]);
        check($sformatf("last%0d", m), 32'(ol[m]), 32'(midx[m] == msize[m] - 1));
      end
    end
  end

  // Record accepted words for literal checks.
  logic [31:0] acc_a [$];
  logic [31:0] acc_b [$];
  logic [31:0] acc_c [$];

  always @(negedge clk) begin
    if (!reset && out_ready) begin
      if (ov[0]) acc_a.push_back(od[0]);
      if (ov[1]) acc_b.push_back(od[1]);
      if (ov[2]) acc_c.push_back(od[2]);
    end
  end

  function automatic logic [31:0] qget(input int m, input int i);
    case (m)
      0: return (i < acc_a.size()) ? acc_a[i] : 32'hxxxx_xxxx;
      1: return (i < acc_b.size()) ? acc_b[i] : 32'hxxxx_xxxx;
      default: return (i < acc_c.size()) ? acc_c[i] : 32'hxxxx_xxxx;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] pkt [5];
  bit          pat [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    acc_a.delete(); acc_b.delete(); acc_c.delete();
  endtask

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      pkg_data = pkt[i];
      tick();
    end
    wr_en = 1'b0;
    pkg_data = 32'h0;
  endtask

  task automatic pulse_fin(input logic [15:0] c);
    fin = 1'b1;
    checksum_in = c;
    tick();
    fin = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (bz == 3'b000 && ov == 3'b000) done = 1'b1;
      else tick();
    end
    check({name, "_idle_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic check_pkt(input string name, input int m, input logic [15:0] lo1);
    check({name, "_w0"}, qget(m, 0), 32'h1234_0050);
    check({name, "_w1"}, qget(m, 1), {16'h0010, lo1});
    check({name, "_w2"}, qget(m, 2), 32'hAABB_CCDD);
    check({name, "_w3"}, qget(m, 3), 32'h0102_0304);
  endtask

  initial begin
    bit seen;
    pkt[0] = 32'h1234_0050; pkt[1] = 32'h0010_0000; pkt[2] = 32'hAABB_CCDD;
    pkt[3] = 32'h0102_0304; pkt[4] = 32'h5566_7788;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;

    reset = 1'b1; wr_en = 1'b0; fin = 1'b0; pkg_data = 32'h0;
    checksum_in = 16'h0; out_ready = 1'b1;
    tick(); tick();
    check("rst_valid", 32'(ov), 32'd0);
    check("rst_busy", 32'(bz), 32'd0);
    check("rst_data", od[0], 32'h0);
    check("rst_err", 32'(er[0]), 32'd0);
    reset = 1'b0;
    tick();

    // Test 1: basic packet, latency, inverted checksum
    clear_acc();
    send_words(4);
    fin = 1'b1; checksum_in = 16'h1A2B;
    tick();
    fin = 1'b0;
    tick();
    check("lat_e1_valid", 32'(ov[0]), 32'd0);
    tick();
    check("lat_e2_valid", 32'(ov[0]), 32'd1);
    check("lat_e2_word0", od[0], 32'h1234_0050);
    wait_idle("t1");
    check("t1_count", 32'(acc_a.size()), 32'd4);
    check_pkt("t1a", 0, 16'hE5D4);
    check_pkt("t2_noinv", 1, 16'h1A2B);

    // Test 2: checksum special values
    clear_acc();
    send_words(4); pulse_fin(16'hFFFF); wait_idle("t2f");
    check("t2_ffff_a", qget(0, 1), 32'h0010_FFFF);
    check("t2_ffff_b", qget(1, 1), 32'h0010_FFFF);
    clear_acc();
    send_words(4); pulse_fin(16'h0000); wait_idle("t2z");
    check("t2_zero_a", qget(0, 1), 32'h0010_0000);

    // Test 3: backpressure pattern during drain
    clear_acc();
    send_words(4); pulse_fin(16'h1A2B);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (ov[0]) seen = 1'b1;
      else tick();
    end
    check("t3_valid_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i];
      tick();
    end
    out_ready = 1'b1;
    wait_idle("t3");
    check("t3_count", 32'(acc_a.size()), 32'd4);
    check_pkt("t3a", 0, 16'hE5D4);

    // Test 4: overflow on the 4-word instance
    clear_acc();
    send_words(5); pulse_fin(16'h1A2B); wait_idle("t4");
    check("t4_err_c", 32'(er[2]), 32'd1);
    check("t4_err_a", 32'(er[0]), 32'd0);
    check("t4_count_c", 32'(acc_c.size()), 32'd4);
    check("t4_count_a", 32'(acc_a.size()), 32'd5);
    check_pkt("t4c", 2, 16'hE5D4);

    // Test 5: short packet
    clear_acc();
    send_words(1);
    check("t5_busy_fill", 32'(bz[0]), 32'd1);
    pulse_fin(16'h1A2B);
    check("t5_busy_after", 32'(bz[0]), 32'd0);
    check("t5_err_a", 32'(er[0]), 32'd2);
    tick(); tick(); tick();
    check("t5_no_output", 32'(acc_a.size()), 32'd0);

    // Test 6: reset mid-drain, then clean packet with fin held high
    clear_acc();
    send_words(4); pulse_fin(16'h1A2B);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (acc_a.size() >= 2) seen = 1'b1;
      else tick();
    end
    check("t6_two_drained", 32'(seen), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(ov), 32'd0);
    check("t6_async_last", 32'(ol), 32'd0);
    check("t6_async_data", od[0], 32'h0);
    check("t6_async_busy", 32'(bz), 32'd0);
    check("t6_async_err_c", 32'(er[2]), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    clear_acc();
    send_words(4);
    fin = 1'b1; checksum_in = 16'h1A2B;
    tick();
    wait_idle("t6");
    check("t6_count", 32'(acc_a.size()), 32'd4);
    check_pkt("t6a", 0, 16'hE5D4);
    for (int i = 0; i < 8; i++) tick();
    check("t6_no_redrain", 32'(acc_a.size()), 32'd4);
    check("t6_idle", 32'(bz[0]), 32'd0);
    fin = 1'b0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
